// File: rtl/ibex_csr_access_ctrl.sv
// ibex_csr_access_ctrl
// Sequencer in front of a bank of single-register CSR cells. It accepts one
// access (read / write / set / clear) at a time, reads the selected cell,
// computes the read-modify-write result, pulses that cell's write enable, and
// returns the pre-access value and an error flag.
//
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   req_*                request channel (valid/ready): addr, op, wdata
//   rsp_*                response channel (valid/ready): old value, error
//   csr_wr_en_o          one-hot write enable, one bit per cell
//   csr_wr_data_o        shared write data for all cells
//   csr_rd_data_i        packed read data, cell i at [i*Width +: Width]
//   csr_rd_error_i       per-cell read-error flag
module ibex_csr_access_ctrl #(
    parameter int unsigned       NumCsr       = 4,
    parameter int unsigned       Width        = 32,
    parameter logic [NumCsr-1:0] ReadOnlyMask = '0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [3:0]              req_addr_i,
    input  logic [1:0]              req_op_i,
    input  logic [Width-1:0]        req_wdata_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [Width-1:0]        rsp_rdata_o,
    output logic                    rsp_error_o,
    output logic [NumCsr-1:0]       csr_wr_en_o,
    output logic [Width-1:0]        csr_wr_data_o,
    input  logic [NumCsr*Width-1:0] csr_rd_data_i,
    input  logic [NumCsr-1:0]       csr_rd_error_i
);

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StWrite,
        StResp
    } state_e;

    typedef enum logic [1:0] {
        OpRead  = 2'b00,
        OpWrite = 2'b01,
        OpSet   = 2'b10,
        OpClear = 2'b11
    } op_e;

    state_e           state_q, state_d;
    logic [3:0]       addr_q;
    op_e              op_q;
    logic [Width-1:0] wdata_q;
    logic [Width-1:0] old_q;
    logic             err_q;
    logic [Width-1:0] wr_data_q;

    // Cell selection; an index with no matching cell leaves addr_legal low
    // and old value zero.
    logic             addr_legal;
    logic [Width-1:0] rd_old;
    logic             cell_err;
    logic             cell_ro;

    always_comb begin
        addr_legal = 1'b0;
        rd_old     = '0;
        cell_err   = 1'b0;
        cell_ro    = 1'b0;
        for (int unsigned i = 0; i < NumCsr; i++) begin
            if (addr_q == 4'(i)) begin
                addr_legal = 1'b1;
                rd_old     = csr_rd_data_i[i*Width +: Width];
                cell_err   = csr_rd_error_i[i];
                cell_ro    = ReadOnlyMask[i];
            end
        end
    end

    logic [Width-1:0] new_val;
    logic             wr_req;
    logic             acc_err;
    logic             do_write;

    always_comb begin
        unique case (op_q)
            OpWrite: new_val = wdata_q;
            OpSet:   new_val = rd_old | wdata_q;
            OpClear: new_val = rd_old & ~wdata_q;
            default: new_val = rd_old;
        endcase
        // SET/CLEAR with a zero operand cannot change the cell, so no write.
        wr_req   = (op_q == OpWrite) ||
                   (((op_q == OpSet) || (op_q == OpClear)) && (wdata_q != '0));
        acc_err  = !addr_legal || cell_err || (wr_req && cell_ro);
        do_write = wr_req && !acc_err;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (req_valid_i) state_d = StRead;
            StRead:  state_d = do_write ? StWrite : StResp;
            StWrite: state_d = StResp;
            StResp:  if (rsp_ready_i) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q    <= '0;
            op_q      <= OpRead;
            wdata_q   <= '0;
            old_q     <= '0;
            err_q     <= 1'b0;
            wr_data_q <= '0;
        end else begin
            if ((state_q == StIdle) && req_valid_i) begin
                addr_q  <= req_addr_i;
                op_q    <= op_e'(req_op_i);
                wdata_q <= req_wdata_i;
            end
            if (state_q == StRead) begin
                old_q <= rd_old;
                err_q <= acc_err;
                if (do_write) begin
                    wr_data_q <= new_val;
                end
            end
        end
    end

    // Handshake and write-enable outputs are gated by rst_i so that nothing
    // is offered or written in the cycle reset is first seen.
    always_comb begin
        req_ready_o = (state_q == StIdle) && !rst_i;
        rsp_valid_o = (state_q == StResp) && !rst_i;
        csr_wr_en_o = '0;
        if ((state_q == StWrite) && !rst_i) begin
            for (int unsigned i = 0; i < NumCsr; i++) begin
                if (addr_q == 4'(i)) begin
                    csr_wr_en_o[i] = 1'b1;
                end
            end
        end
    end

    assign rsp_rdata_o   = old_q;
    assign rsp_error_o   = err_q;
    assign csr_wr_data_o = wr_data_q;

endmodule

// File: tb/tb_ibex_csr_access_ctrl.sv
// Self-checking bench for ibex_csr_access_ctrl: the bench owns the CSR cell
// bank, predicts each access outcome from the access rules, and checks
// latency, response, write pulses and reset behaviour.
module tb_ibex_csr_access_ctrl;

    localparam int unsigned N  = 4;
    localparam int unsigned W  = 32;
    localparam logic [3:0]  RO = 4'b1000;

    logic           clk = 1'b0;
    logic           rst;
    logic           req_valid;
    logic           req_ready;
    logic [3:0]     req_addr;
    logic [1:0]     req_op;
    logic [W-1:0]   req_wdata;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [W-1:0]   rsp_rdata;
    logic           rsp_error;
    logic [N-1:0]   csr_wr_en;
    logic [W-1:0]   csr_wr_data;
    logic [N*W-1:0] csr_rd_data;
    logic [N-1:0]   rderr;

    logic [W-1:0]   mem [N];

    assign csr_rd_data = {mem[3], mem[2], mem[1], mem[0]};

    always #5 clk = ~clk;

    ibex_csr_access_ctrl #(
        .NumCsr      (N),
        .Width       (W),
        .ReadOnlyMask(RO)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_addr_i    (req_addr),
        .req_op_i      (req_op),
        .req_wdata_i   (req_wdata),
        .rsp_valid_o   (rsp_valid),
        .rsp_ready_i   (rsp_ready),
        .rsp_rdata_o   (rsp_rdata),
        .rsp_error_o   (rsp_error),
        .csr_wr_en_o   (csr_wr_en),
        .csr_wr_data_o (csr_wr_data),
        .csr_rd_data_i (csr_rd_data),
        .csr_rd_error_i(rderr)
    );

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One complete access, entered and left at a negedge with the DUT idle.
    task automatic do_access(input logic [3:0] addr, input logic [1:0] op,
                             input logic [31:0] wdata, input int hold, input bit poke);
        logic [31:0] old, newv, en_seen, data_seen;
        bit legal, wants_wr, err, dw, got;
        int cnt, wr_cnt;

        // Reference outcome from the access rules.
        legal    = (addr < 4'd4);
        old      = legal ? mem[addr[1:0]] : 32'h0;
        wants_wr = (op == 2'd1) || ((op != 2'd0) && (wdata != 32'h0));
        err      = !legal;
        if (legal && (rderr[addr[1:0]] || (wants_wr && RO[addr[1:0]]))) err = 1'b1;
        case (op)
            2'd1:    newv = wdata;
            2'd2:    newv = old | wdata;
            2'd3:    newv = old & ~wdata;
            default: newv = old;
        endcase
        dw = wants_wr && !err;

        check_eq("req_ready_idle", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_addr  = addr;
        req_op    = op;
        req_wdata = wdata;
        next_cycle();
        req_valid = 1'b0;
        req_addr  = 4'($urandom);
        req_op    = 2'($urandom);
        req_wdata = $urandom;

        cnt = 1; got = 0; wr_cnt = 0; en_seen = 0; data_seen = 0;
        while (cnt <= 10) begin
            if (csr_wr_en != '0) begin
                wr_cnt++;
                en_seen   = {28'b0, csr_wr_en};
                data_seen = csr_wr_data;
                for (int i = 0; i < 4; i++) if (csr_wr_en[i]) mem[i] = csr_wr_data;
            end
            if (rsp_valid) begin
                got = 1;
                break;
            end
            check_eq("req_ready_busy", {31'b0, req_ready}, 32'd0);
            next_cycle();
            cnt++;
        end

        if (!got) begin
            check_eq("rsp_timeout", 32'd0, 32'd1);
        end else begin
            check_eq("latency", 32'(cnt), dw ? 32'd3 : 32'd2);
            check_eq("rdata", rsp_rdata, old);
            check_eq("error", {31'b0, rsp_error}, {31'b0, err});
            check_eq("wr_pulses", 32'(wr_cnt), dw ? 32'd1 : 32'd0);
            if (dw) begin
                check_eq("wr_en_onehot", en_seen, 32'd1 << addr);
                check_eq("wr_data", data_seen, newv);
            end
            for (int k = 0; k < hold; k++) begin
                if (poke) begin
                    req_valid = 1'b1;
                    req_addr  = 4'($urandom_range(0, 3));
                end
                next_cycle();
                check_eq("hold_valid", {31'b0, rsp_valid}, 32'd1);
                check_eq("hold_rdata", rsp_rdata, old);
                check_eq("hold_error", {31'b0, rsp_error}, {31'b0, err});
                check_eq("hold_req_ready", {31'b0, req_ready}, 32'd0);
            end
            req_valid = 1'b0;
            rsp_ready = 1'b1;
            next_cycle();
            rsp_ready = 1'b0;
            check_eq("rsp_drop", {31'b0, rsp_valid}, 32'd0);
        end
    endtask

    task automatic reset_mid_write();
        mem[1] = 32'h1234_5678;
        check_eq("rst_req_ready", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_addr  = 4'd1;
        req_op    = 2'd1;
        req_wdata = 32'hCAFE_F00D;
        next_cycle();
        req_valid = 1'b0;
        rst = 1'b1;
        next_cycle();
        check_eq("rst_wr_en", {28'b0, csr_wr_en}, 32'd0);
        check_eq("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check_eq("rst_req_ready_low", {31'b0, req_ready}, 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            check_eq("post_rst_wr_en", {28'b0, csr_wr_en}, 32'd0);
            check_eq("post_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
            check_eq("post_rst_req_ready", {31'b0, req_ready}, 32'd1);
        end
        check_eq("post_rst_wr_data", csr_wr_data, 32'd0);
        check_eq("post_rst_rdata", rsp_rdata, 32'd0);
        check_eq("post_rst_cell", mem[1], 32'h1234_5678);
    endtask

    initial begin
        logic [3:0]  a;
        logic [1:0]  o;
        logic [31:0] wd;

        rst       = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_op    = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;
        rderr     = '0;
        for (int i = 0; i < 4; i++) mem[i] = '0;

        next_cycle();
        next_cycle();
        check_eq("reset_req_ready", {31'b0, req_ready}, 32'd0);
        check_eq("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check_eq("reset_rdata", rsp_rdata, 32'd0);
        check_eq("reset_error", {31'b0, rsp_error}, 32'd0);
        check_eq("reset_wr_en", {28'b0, csr_wr_en}, 32'd0);
        check_eq("reset_wr_data", csr_wr_data, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        mem[2] = 32'hDEAD_BEEF;
        do_access(4'd2, 2'd0, 32'h0, 0, 0);
        mem[1] = 32'h0000_000F;
        do_access(4'd1, 2'd2, 32'h0000_00F0, 0, 0);
        check_eq("set_cell_result", mem[1], 32'h0000_00FF);
        mem[0] = 32'hA5A5_0001;
        do_access(4'd0, 2'd3, 32'h0, 0, 0);
        do_access(4'd5, 2'd1, 32'h1111_2222, 0, 0);
        mem[3] = 32'h3333_4444;
        do_access(4'd3, 2'd1, 32'h5555_6666, 0, 0);
        check_eq("ro_cell_kept", mem[3], 32'h3333_4444);
        rderr = 4'b0010;
        do_access(4'd1, 2'd1, 32'h7777_8888, 0, 0);
        rderr = '0;
        do_access(4'd2, 2'd0, 32'h0, 5, 1);
        reset_mid_write();

        for (int t = 0; t < 60; t++) begin
            a  = 4'($urandom_range(0, 5));
            o  = 2'($urandom);
            wd = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            if ($urandom_range(0, 2) == 0) mem[$urandom_range(0, 3)] = $urandom;
            rderr = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0;
            do_access(a, o, wd, $urandom_range(0, 3), ($urandom_range(0, 1) == 1));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ibex_csr_access_ctrl.md
Name: ibex_csr_access_ctrl

Overview:
- Sequencer directly upstream of a bank of single-register CSR storage cells.
- Accepts CSR access requests (read, write, set, clear) over a valid/ready interface and performs the read-modify-write against the selected cell.
- Drives each cell's write enable and write data, consumes each cell's read data and read-error flag, and returns the pre-write value plus an error flag over a valid/ready response interface.

Parameters:
- NumCsr, 4, number of attached CSR cells (1..16).
- Width, 32, data width of every CSR.
- ReadOnlyMask, {NumCsr{1'b0}}, bit i set means CSR i rejects any write attempt.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  synchronous reset, active-high.
- req_valid_i  input  1  request valid.
- req_ready_o  output  1  request accepted when valid and ready are both high.
- req_addr_i  input  4  CSR index; values >= NumCsr are illegal.
- req_op_i  input  2  operation: 00 READ, 01 WRITE, 10 SET, 11 CLEAR.
- req_wdata_i  input  Width  operand.
- rsp_valid_o  output  1  response valid.
- rsp_ready_i  input  1  response consumed when valid and ready are both high.
- rsp_rdata_o  output  Width  CSR value before the access.
- rsp_error_o  output  1  access failed.
- csr_wr_en_o  output  NumCsr  one-hot write enable, one bit per cell.
- csr_wr_data_o  output  Width  shared write data.
- csr_rd_data_i  input  NumCsr*Width  cell i read data at bits [i*Width +: Width].
- csr_rd_error_i  input  NumCsr  per-cell read-error flag (shadow mismatch).

Behaviour:
- Clock and reset: one clock (clk_i). Synchronous active-high reset (rst_i), sampled on the rising edge of clk_i.
- Reset values:
  - state IDLE;
  - req_ready_o=0 while rst_i is high, 1 in IDLE otherwise;
  - rsp_valid_o=0, rsp_rdata_o=0, rsp_error_o=0;
  - csr_wr_en_o=0, csr_wr_data_o=0;
  - all internal latches 0.
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE:
  - req_ready_o=1.
  - On handshake, latch addr/op/wdata and go to READ.
  - No other outputs change.
- READ (one cycle):
  - Capture old = csr_rd_data_i slice[addr]; old = 0 if addr is illegal.
  - Compute new value: WRITE gives wdata; SET gives old|wdata; CLEAR gives old&~wdata; READ performs no write.
  - Write is requested when op==WRITE, or when op is SET/CLEAR with wdata != 0.
  - err = illegal addr OR csr_rd_error_i[addr] OR (write requested AND ReadOnlyMask[addr]).
  - Write requested and !err: register new value into csr_wr_data_o and go to WRITE.
  - Otherwise: go to RESP.
- WRITE (one cycle):
  - csr_wr_en_o[addr]=1 for exactly this cycle; all other bits 0.
  - csr_wr_data_o holds the new value.
  - Next state RESP.
- RESP:
  - rsp_valid_o=1; rsp_rdata_o=old; rsp_error_o=err. These stay stable until rsp_ready_i is high.
  - On handshake, go to IDLE; rsp_valid_o drops the next cycle.
- Latency, counted from request-accept edge to first rsp_valid_o cycle:
  - 2 cycles with no write;
  - 3 cycles with a write.
- Throughput: one access in flight; req_ready_o=0 outside IDLE. A new request can be accepted the cycle after the response handshake.
- csr_wr_en_o is never asserted on error, for READ, or for SET/CLEAR with a zero operand.
- csr_wr_data_o retains its last value when not writing; it is meaningful only with a write enable.
- Reset mid-operation:
  - returns to IDLE on the next edge;
  - no write enable is issued after reset is asserted;
  - any pending response is dropped.
- Read data is sampled only in READ; changes on csr_rd_data_i in other states are ignored.

Test Plan:
- Reset, then READ addr 2 with cell 2 = 0xDEADBEEF -> rsp_valid_o 2 cycles after accept, rdata 0xDEADBEEF, error 0, csr_wr_en_o stays 0.
- SET addr 1, wdata 0x0000_00F0, cell 1 = 0x0000_000F -> one cycle of csr_wr_en_o=4'b0010 with data 0x0000_00FF; rsp rdata 0x0000_000F, error 0, latency 3.
- CLEAR addr 0 with wdata 0 -> no write enable, rdata = cell 0, error 0. WRITE addr 5 with NumCsr=4 -> no write, rdata 0, error 1.
- ReadOnlyMask=4'b1000: WRITE addr 3 -> error 1, no write, rdata = cell 3. Separately, csr_rd_error_i[1]=1 on WRITE addr 1 -> error 1, no write.
- Hold rsp_ready_i=0 for 5 cycles -> rsp_valid/rdata/error stable and req_ready_o=0 throughout. Drive req_valid_i during this window -> request not accepted until after the response handshake.
- Assert rst_i during the WRITE-bound READ cycle -> csr_wr_en_o stays 0, rsp_valid_o never rises, req_ready_o=1 the cycle after rst_i deasserts.
